// File: rtl/jedro_1_lsu_gen_if.sv
// Purpose: bundles the jedro-1 LSU control, writeback, exception and data-memory signals.
// Latency: none; wiring only.
// Backpressure: carries ctrl valid/ready towards the core and req/gnt/rvalid towards memory.
interface jedro_1_lsu_gen_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // Operation issue from decoder/ALU
    logic                      ctrl_valid_i;
    logic                      ctrl_ready_o;
    logic [3:0]                ctrl_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [REG_ADDR_WIDTH-1:0] regdest_i;

    // Register-file writeback
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      rf_wb_o;
    logic [REG_ADDR_WIDTH-1:0] regdest_o;

    // Exception report
    logic                      exc_misaligned_o;
    logic [ADDR_WIDTH-1:0]     exc_addr_o;

    // Data-memory port
    logic                      mem_req_o;
    logic                      mem_gnt_i;
    logic [ADDR_WIDTH-1:0]     mem_addr_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic                      mem_rvalid_i;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    // LSU side: accepts operations, masters the memory port
    modport master (
        input  ctrl_valid_i, ctrl_i, addr_i, wdata_i, regdest_i,
        output ctrl_ready_o,
        output rdata_o, rf_wb_o, regdest_o,
        output exc_misaligned_o, exc_addr_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    // Environment side: core issuing operations plus the memory responder
    modport slave (
        output ctrl_valid_i, ctrl_i, addr_i, wdata_i, regdest_i,
        input  ctrl_ready_o,
        input  rdata_o, rf_wb_o, regdest_o,
        input  exc_misaligned_o, exc_addr_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/jedro_1_lsu_gen.sv
// Purpose: jedro-1 load-store unit: lane alignment, store replication, load extension, misalign detect.
// Latency: request registered 1 cycle after accept; load writeback 1 cycle after rvalid.
// Backpressure: ready drops while a request waits for gnt or MAX_OUTSTANDING loads are in flight.
module jedro_1_lsu_gen #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    jedro_1_lsu_gen_if.master  bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Everything needed to finish a load once its data returns
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] regdest;
        logic [2:0]                funct3;
        logic [OFF_W-1:0]          off;
    } tag_t;

    // Decode of the offered operation
    logic             is_store;
    logic [2:0]       funct3;
    logic [1:0]       size;
    logic [OFF_W-1:0] off;
    logic [3:0]       nbytes_m1;
    logic             illegal;
    logic             misaligned;
    logic             bad_op;

    assign is_store   = bus.ctrl_i[3];
    assign funct3     = bus.ctrl_i[2:0];
    assign size       = funct3[1:0];
    assign off        = bus.addr_i[OFF_W-1:0];
    assign nbytes_m1  = (4'd1 << size) - 4'd1;
    assign misaligned = |(off & nbytes_m1[OFF_W-1:0]);
    assign bad_op     = illegal | misaligned;

    // Encodings that this bus width cannot serve are routed to the exception path
    always_comb begin
        illegal = 1'b0;
        if (funct3 == 3'b111)                        illegal = 1'b1;
        if (is_store && funct3[2])                   illegal = 1'b1;
        if ((DATA_WIDTH != 64) && (size == 2'b11))   illegal = 1'b1;
        if ((DATA_WIDTH != 64) && (funct3 == 3'b110)) illegal = 1'b1;
    end

    // Registered state
    logic                    mem_req_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_we_q;
    logic [BE_W-1:0]         mem_be_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rf_wb_q;
    logic [REG_ADDR_WIDTH-1:0] regdest_q;
    logic                    exc_q;
    logic [ADDR_WIDTH-1:0]   exc_addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    tag_t                    tag_mem [MAX_OUTSTANDING];

    // Handshake qualifiers
    logic ready;
    logic accept;
    logic issue;
    logic push;
    logic pop;

    assign ready  = (!mem_req_q || bus.mem_gnt_i) && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign accept = bus.ctrl_valid_i && ready;
    assign issue  = accept && !bad_op;
    assign push   = issue && !is_store;
    assign pop    = bus.mem_rvalid_i && (cnt_q != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Store lane data: replicate the low bytes of the operand across every lane of the access size
    logic [DATA_WIDTH-1:0] st_data;
    logic [7:0]            size_mask;
    logic [BE_W-1:0]       st_be;

    always_comb begin
        case (size)
            2'b00:   st_data = {(DATA_WIDTH/8){bus.wdata_i[7:0]}};
            2'b01:   st_data = {(DATA_WIDTH/16){bus.wdata_i[15:0]}};
            2'b10:   st_data = {(DATA_WIDTH/32){bus.wdata_i[31:0]}};
            default: st_data = bus.wdata_i;
        endcase
        case (size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        st_be = BE_W'(size_mask) << off;
    end

    // Load result: move the addressed bytes to bit 0, then sign- or zero-extend
    tag_t                  head;
    logic [DATA_WIDTH-1:0] ld_shift;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] ld_data;

    assign head     = tag_mem[rd_ptr_q];
    assign ld_shift = bus.mem_rdata_i >> {head.off, 3'b000};

    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (head.funct3[1:0])
            2'b00: begin
                keep_mask = DATA_WIDTH'(8'hFF);
                sign_bit  = ld_shift[7];
            end
            2'b01: begin
                keep_mask = DATA_WIDTH'(16'hFFFF);
                sign_bit  = ld_shift[15];
            end
            2'b10: begin
                keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_bit  = ld_shift[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        ld_data = (ld_shift & keep_mask) |
                  ((sign_bit && !head.funct3[2]) ? ~keep_mask : '0);
    end

    // Memory request register: load on a legal accept, otherwise hold until granted
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else if (issue) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= bus.addr_i & ~ADDR_WIDTH'(BE_W - 1);
            mem_we_q    <= is_store;
            mem_be_q    <= st_be;
            mem_wdata_q <= st_data;
        end else if (bus.mem_gnt_i) begin
            mem_req_q   <= 1'b0;
        end
    end

    // Exception pulse for misaligned or unsupported operations
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
        end else if (accept && bad_op) begin
            exc_q      <= 1'b1;
            exc_addr_q <= bus.addr_i;
        end else begin
            exc_q      <= 1'b0;
        end
    end

    // Load tag FIFO and outstanding count; rvalid with nothing pending is dropped
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr_q] <= '{regdest: bus.regdest_i, funct3: funct3, off: off};
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Writeback register: one-cycle strobe, data and destination held between strobes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rf_wb_q   <= 1'b0;
            rdata_q   <= '0;
            regdest_q <= '0;
        end else if (pop) begin
            rf_wb_q   <= 1'b1;
            rdata_q   <= ld_data;
            regdest_q <= head.regdest;
        end else begin
            rf_wb_q   <= 1'b0;
        end
    end

    assign bus.ctrl_ready_o     = ready;
    assign bus.mem_req_o        = mem_req_q;
    assign bus.mem_addr_o       = mem_addr_q;
    assign bus.mem_we_o         = mem_we_q;
    assign bus.mem_be_o         = mem_be_q;
    assign bus.mem_wdata_o      = mem_wdata_q;
    assign bus.rdata_o          = rdata_q;
    assign bus.rf_wb_o          = rf_wb_q;
    assign bus.regdest_o        = regdest_q;
    assign bus.exc_misaligned_o = exc_q;
    assign bus.exc_addr_o       = exc_addr_q;
endmodule

// File: tb/tb_jedro_1_lsu_gen.sv
// Purpose: directed self-checking bench for jedro_1_lsu_gen (DATA_WIDTH=32, MAX_OUTSTANDING=2).
// Latency: checks request at T+1 and writeback at rvalid+1.
// Backpressure: exercises gnt stalls and the outstanding-load limit.
module tb_jedro_1_lsu_gen;
    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    jedro_1_lsu_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    jedro_1_lsu_gen #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        bus.ctrl_valid_i = 1'b1;
        bus.ctrl_i       = ctrl;
        bus.addr_i       = addr;
        bus.wdata_i      = wdata;
        bus.regdest_i    = rd;
    endtask

    // Load with minimum latency: accept, gnt next cycle, rvalid the cycle after
    task automatic do_load(input string tag, input logic [3:0] ctrl, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp);
        set_op(ctrl, addr, 32'h0, rd);
        tick();
        bus.ctrl_valid_i = 1'b0;
        bus.mem_gnt_i    = 1'b1;
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = rdata;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk({tag, "_wb"}, bus.rf_wb_o, 1'b1);
        chk({tag, "_data"}, bus.rdata_o, exp);
        chk({tag, "_rd"}, bus.regdest_o, rd);
    endtask

    initial begin
        rstn             = 1'b0;
        bus.ctrl_valid_i = 1'b0;
        bus.ctrl_i       = 4'h0;
        bus.addr_i       = 32'h0;
        bus.wdata_i      = 32'h0;
        bus.regdest_i    = 5'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        #2;
        chk("rst_req",   bus.mem_req_o, 1'b0);
        chk("rst_wb",    bus.rf_wb_o, 1'b0);
        chk("rst_exc",   bus.exc_misaligned_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_ready", bus.ctrl_ready_o, 1'b1);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // LW at 0x100, stepped cycle by cycle
        set_op(4'b0010, 32'h100, 32'h0, 5'd7);
        #1;
        chk("lw_ready_idle", bus.ctrl_ready_o, 1'b1);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("lw_req",      bus.mem_req_o, 1'b1);
        chk("lw_addr",     bus.mem_addr_o, 32'h100);
        chk("lw_we",       bus.mem_we_o, 1'b0);
        chk("lw_ready_wait", bus.ctrl_ready_o, 1'b0);
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("lw_ready_gnt", bus.ctrl_ready_o, 1'b1);
        tick();
        bus.mem_gnt_i = 1'b0;
        chk("lw_req_drop", bus.mem_req_o, 1'b0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h8899AABB;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("lw_wb",    bus.rf_wb_o, 1'b1);
        chk("lw_data",  bus.rdata_o, 32'h8899AABB);
        chk("lw_rd",    bus.regdest_o, 5'd7);
        tick();
        chk("lw_wb_pulse", bus.rf_wb_o, 1'b0);
        chk("lw_data_hold", bus.rdata_o, 32'h8899AABB);

        // Sub-word loads with extension
        do_load("lb",  4'b0000, 32'h103, 5'd3, 32'h80123456, 32'hFFFFFF80);
        do_load("lbu", 4'b0100, 32'h103, 5'd4, 32'h80123456, 32'h00000080);
        do_load("lb_pos", 4'b0000, 32'h101, 5'd5, 32'h00007F00, 32'h0000007F);
        do_load("lh",  4'b0001, 32'h102, 5'd6, 32'h80001234, 32'hFFFF8000);
        do_load("lhu", 4'b0101, 32'h102, 5'd8, 32'h80001234, 32'h00008000);
        do_load("lw_x0", 4'b0010, 32'h104, 5'd0, 32'h01020304, 32'h01020304);

        // SH at 0x102
        set_op(4'b1001, 32'h102, 32'h1234ABCD, 5'd0);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("sh_req",   bus.mem_req_o, 1'b1);
        chk("sh_we",    bus.mem_we_o, 1'b1);
        chk("sh_be",    bus.mem_be_o, 4'b1100);
        chk("sh_wdata", bus.mem_wdata_o, 32'hABCDABCD);
        chk("sh_addr",  bus.mem_addr_o, 32'h100);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        chk("sh_no_wb", bus.rf_wb_o, 1'b0);
        tick();
        chk("sh_no_wb2", bus.rf_wb_o, 1'b0);

        // SB at 0x101
        set_op(4'b1000, 32'h101, 32'h000000EF, 5'd0);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("sb_be",    bus.mem_be_o, 4'b0010);
        chk("sb_wdata", bus.mem_wdata_o, 32'hEFEFEFEF);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;

        // Misaligned LW at 0x101
        set_op(4'b0010, 32'h101, 32'h0, 5'd9);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("mis_req",  bus.mem_req_o, 1'b0);
        chk("mis_exc",  bus.exc_misaligned_o, 1'b1);
        chk("mis_addr", bus.exc_addr_o, 32'h101);
        tick();
        chk("mis_pulse", bus.exc_misaligned_o, 1'b0);
        chk("mis_no_wb", bus.rf_wb_o, 1'b0);

        // LD is illegal on a 32-bit bus
        set_op(4'b0011, 32'h200, 32'h0, 5'd9);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("ld_req", bus.mem_req_o, 1'b0);
        chk("ld_exc", bus.exc_misaligned_o, 1'b1);
        chk("ld_addr", bus.exc_addr_o, 32'h200);
        // Store with funct3[2] set is illegal
        set_op(4'b1100, 32'h204, 32'h0, 5'd0);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("sbu_req", bus.mem_req_o, 1'b0);
        chk("sbu_exc", bus.exc_misaligned_o, 1'b1);
        tick();

        // Outstanding limit with rvalid withheld, gnt always high
        bus.mem_gnt_i = 1'b1;
        set_op(4'b0010, 32'h200, 32'h0, 5'd10);
        tick();
        set_op(4'b0010, 32'h204, 32'h0, 5'd11);
        #1;
        chk("mo_ready_1", bus.ctrl_ready_o, 1'b1);
        tick();
        set_op(4'b0010, 32'h208, 32'h0, 5'd12);
        #1;
        chk("mo_ready_full", bus.ctrl_ready_o, 1'b0);
        chk("mo_addr2", bus.mem_addr_o, 32'h204);
        tick();
        chk("mo_ready_full2", bus.ctrl_ready_o, 1'b0);
        chk("mo_req_idle", bus.mem_req_o, 1'b0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h11111111;
        #1;
        chk("mo_ready_pop", bus.ctrl_ready_o, 1'b0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("mo_wb1",    bus.rf_wb_o, 1'b1);
        chk("mo_rd1",    bus.regdest_o, 5'd10);
        chk("mo_data1",  bus.rdata_o, 32'h11111111);
        chk("mo_ready_after", bus.ctrl_ready_o, 1'b1);
        tick();
        bus.ctrl_valid_i = 1'b0;
        chk("mo_req3",  bus.mem_req_o, 1'b1);
        chk("mo_addr3", bus.mem_addr_o, 32'h208);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h22222222;
        tick();
        chk("mo_rd2",   bus.regdest_o, 5'd11);
        chk("mo_data2", bus.rdata_o, 32'h22222222);
        bus.mem_rdata_i = 32'h33333333;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        chk("mo_rd3",   bus.regdest_o, 5'd12);
        chk("mo_data3", bus.rdata_o, 32'h33333333);
        tick();
        chk("mo_wb_end", bus.rf_wb_o, 1'b0);

        // gnt withheld for three cycles on a SW
        set_op(4'b1010, 32'h300, 32'hDEADBEEF, 5'd0);
        tick();
        bus.ctrl_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req",   bus.mem_req_o, 1'b1);
            chk("stall_addr",  bus.mem_addr_o, 32'h300);
            chk("stall_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
            chk("stall_be",    bus.mem_be_o, 4'b1111);
            chk("stall_ready", bus.ctrl_ready_o, 1'b0);
            tick();
        end
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("stall_gnt_ready", bus.ctrl_ready_o, 1'b1);
        tick();
        bus.mem_gnt_i = 1'b0;
        chk("stall_req_drop", bus.mem_req_o, 1'b0);

        // Reset with two loads outstanding
        bus.mem_gnt_i = 1'b1;
        set_op(4'b0010, 32'h400, 32'h0, 5'd20);
        tick();
        set_op(4'b0010, 32'h404, 32'h0, 5'd21);
        tick();
        bus.ctrl_valid_i = 1'b0;
        tick();
        bus.mem_gnt_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mrst_req",   bus.mem_req_o, 1'b0);
        chk("mrst_addr",  bus.mem_addr_o, 32'h0);
        chk("mrst_be",    bus.mem_be_o, 4'h0);
        chk("mrst_wdata", bus.mem_wdata_o, 32'h0);
        chk("mrst_rdata", bus.rdata_o, 32'h0);
        chk("mrst_rd",    bus.regdest_o, 5'd0);
        chk("mrst_exc_addr", bus.exc_addr_o, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h44444444;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("mrst_late_wb",    bus.rf_wb_o, 1'b0);
        chk("mrst_late_rdata", bus.rdata_o, 32'h0);
        chk("mrst_ready",      bus.ctrl_ready_o, 1'b1);
        do_load("post_rst", 4'b0010, 32'h500, 5'd22, 32'hCAFEF00D, 32'hCAFEF00D);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
